// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and
// instruction memory: single-outstanding request with grant and read-valid.
interface if_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/if_stage.sv
// MIPS instruction fetch stage: PC, single-outstanding imem fetch, IF/ID register.
// Optional perf counters are enabled by defining IF_STAGE_PERF_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.master  imem,
  input  logic        hold,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] req_pc_r, req_pc_s;
  logic [31:0] skid_instr_r, skid_instr_s;
  logic [31:0] skid_pc4_r, skid_pc4_s;
  logic        discard_r, discard_s;
  logic        load_s;
  logic [31:0] load_instr_s;
  logic [31:0] load_pc4_s;
  logic        ifid_valid_s;
  logic [31:0] ifid_instr_s;
  logic [31:0] ifid_pc4_s;

  // Request side is decoded from registers only, never from inputs.
  assign imem.req  = (state_r == ST_REQ);
  assign imem.addr = pc_r;

  // Next-state, PC and skid logic; redirect overrides everything else.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    req_pc_s     = req_pc_r;
    skid_instr_s = skid_instr_r;
    skid_pc4_s   = skid_pc4_r;
    discard_s    = discard_r;
    load_s       = 1'b0;
    load_instr_s = 32'h0000_0000;
    load_pc4_s   = 32'h0000_0000;
    if (redirect) begin
      pc_s = redirect_pc;
      case (state_r)
        ST_REQ: begin
          // A request granted alongside the redirect still returns data we must drop.
          if (imem.gnt) begin
            state_s   = ST_WAIT;
            discard_s = 1'b1;
          end else begin
            state_s = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem.rvalid) begin
            state_s   = ST_REQ;
            discard_s = 1'b0;
          end else begin
            state_s   = ST_WAIT;
            discard_s = 1'b1;
          end
        end
        ST_FULL: begin
          state_s = ST_REQ;
        end
        default: begin
          state_s   = ST_REQ;
          discard_s = 1'b0;
        end
      endcase
    end else begin
      case (state_r)
        ST_REQ: begin
          if (imem.gnt) begin
            req_pc_s = pc_r;
            pc_s     = pc_r + 32'd4;
            state_s  = ST_WAIT;
          end else begin
            state_s = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (!imem.rvalid) begin
            state_s = ST_WAIT;
          end else if (discard_r) begin
            discard_s = 1'b0;
            state_s   = ST_REQ;
          end else if (!hold) begin
            load_s       = 1'b1;
            load_instr_s = imem.rdata;
            load_pc4_s   = req_pc_r + 32'd4;
            state_s      = ST_REQ;
          end else begin
            skid_instr_s = imem.rdata;
            skid_pc4_s   = req_pc_r + 32'd4;
            state_s      = ST_FULL;
          end
        end
        ST_FULL: begin
          if (!hold) begin
            load_s       = 1'b1;
            load_instr_s = skid_instr_r;
            load_pc4_s   = skid_pc4_r;
            state_s      = ST_REQ;
          end else begin
            state_s = ST_FULL;
          end
        end
        default: begin
          state_s   = ST_REQ;
          discard_s = 1'b0;
        end
      endcase
    end
  end

  // IF/ID next value: new word, bubble (pc4 kept), or held contents.
  always_comb begin
    ifid_valid_s = ifid_valid;
    ifid_instr_s = ifid_instr;
    ifid_pc4_s   = ifid_pc4;
    if (load_s) begin
      ifid_valid_s = 1'b1;
      ifid_instr_s = load_instr_s;
      ifid_pc4_s   = load_pc4_s;
    end else if (redirect || !hold) begin
      ifid_valid_s = 1'b0;
      ifid_instr_s = 32'h0000_0000;
    end else begin
      ifid_valid_s = ifid_valid;
    end
  end

  // State, PC, skid and IF/ID registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_REQ;
      pc_r         <= RESET_PC;
      req_pc_r     <= 32'h0000_0000;
      skid_instr_r <= 32'h0000_0000;
      skid_pc4_r   <= 32'h0000_0000;
      discard_r    <= 1'b0;
      ifid_valid   <= 1'b0;
      ifid_instr   <= 32'h0000_0000;
      ifid_pc4     <= 32'h0000_0000;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      req_pc_r     <= req_pc_s;
      skid_instr_r <= skid_instr_s;
      skid_pc4_r   <= skid_pc4_s;
      discard_r    <= discard_s;
      ifid_valid   <= ifid_valid_s;
      ifid_instr   <= ifid_instr_s;
      ifid_pc4     <= ifid_pc4_s;
    end
  end

`ifdef IF_STAGE_PERF_EN
  // Fetch and stall counters, free-running and wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= 32'h0000_0000;
      perf_stall   <= 32'h0000_0000;
    end else begin
      perf_fetched <= perf_fetched + {31'd0, load_s};
      perf_stall   <= perf_stall + {31'd0, (hold & ifid_valid)};
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; the bench acts as instruction memory.
// Inputs change and outputs are checked on the falling clock edge.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        hold;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
`ifdef IF_STAGE_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int vectors = 0;
  int miscompares = 0;

  if_stage_if imem ();

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem.master),
    .hold        (hold),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4)
`ifdef IF_STAGE_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    step();
    vectors++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_req: req=%0b addr=%h, want req=1 addr=00000000", imem.req, imem.addr);
    end
    vectors++;
    if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_ifid: v=%0b i=%h p=%h, want 0/0/0", ifid_valid, ifid_instr, ifid_pc4);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic_fetch();
    vectors++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin
      miscompares++;
      $display("FAIL basic_addr0: req=%0b addr=%h, want 1/00000000", imem.req, imem.addr);
    end
    imem.gnt = 1'b1;
    step();
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b1;
    imem.rdata  = 32'h2008_0005;
    vectors++;
    if (imem.req !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_wait_req: req=%0b, want 0", imem.req);
    end
    step();
    imem.rvalid = 1'b0;
    vectors++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 32'h2008_0005 || ifid_pc4 !== 32'h4) begin
      miscompares++;
      $display("FAIL basic_ifid: v=%0b i=%h p=%h, want 1/20080005/00000004", ifid_valid, ifid_instr, ifid_pc4);
    end
    vectors++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h4) begin
      miscompares++;
      $display("FAIL basic_next_addr: req=%0b addr=%h, want 1/00000004", imem.req, imem.addr);
    end
  endtask

  task automatic test_hold_skid();
    hold     = 1'b1;
    imem.gnt = 1'b1;
    step();
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b1;
    imem.rdata  = 32'h8C09_0010;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (imem.req !== 1'b0 || ifid_valid !== 1'b1 || ifid_instr !== 32'h2008_0005 || ifid_pc4 !== 32'h4) begin
        miscompares++;
        $display("FAIL hold_parked[%0d]: req=%0b v=%0b i=%h p=%h, want 0/1/20080005/00000004",
                 i, imem.req, ifid_valid, ifid_instr, ifid_pc4);
      end
      step();
      imem.rvalid = 1'b0;
    end
    hold = 1'b0;
    step();
    vectors++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 32'h8C09_0010 || ifid_pc4 !== 32'h8) begin
      miscompares++;
      $display("FAIL hold_release: v=%0b i=%h p=%h, want 1/8c090010/00000008", ifid_valid, ifid_instr, ifid_pc4);
    end
    vectors++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h8) begin
      miscompares++;
      $display("FAIL hold_next_addr: req=%0b addr=%h, want 1/00000008", imem.req, imem.addr);
    end
  endtask

  task automatic test_redirect_wait();
    imem.gnt = 1'b1;
    step();
    imem.gnt    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    vectors++;
    if (imem.req !== 1'b0 || ifid_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_wait_state: req=%0b v=%0b, want 0/0", imem.req, ifid_valid);
    end
    imem.rvalid = 1'b1;
    imem.rdata  = 32'hDEAD_BEEF;
    step();
    imem.rvalid = 1'b0;
    vectors++;
    if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
      miscompares++;
      $display("FAIL redir_discard: v=%0b i=%h, want 0/00000000", ifid_valid, ifid_instr);
    end
    vectors++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h100) begin
      miscompares++;
      $display("FAIL redir_target: req=%0b addr=%h, want 1/00000100", imem.req, imem.addr);
    end
    imem.gnt = 1'b1;
    step();
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b1;
    imem.rdata  = 32'h0109_5020;
    step();
    imem.rvalid = 1'b0;
    vectors++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 32'h0109_5020 || ifid_pc4 !== 32'h104) begin
      miscompares++;
      $display("FAIL redir_deliver: v=%0b i=%h p=%h, want 1/01095020/00000104", ifid_valid, ifid_instr, ifid_pc4);
    end
  endtask

  task automatic test_redirect_gnt();
    hold        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    imem.gnt    = 1'b1;
    step();
    redirect = 1'b0;
    imem.gnt = 1'b0;
    vectors++;
    if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || imem.req !== 1'b0) begin
      miscompares++;
      $display("FAIL rgnt_flush: v=%0b i=%h req=%0b, want 0/00000000/0", ifid_valid, ifid_instr, imem.req);
    end
    imem.rvalid = 1'b1;
    imem.rdata  = 32'hBAD0_BAD0;
    step();
    imem.rvalid = 1'b0;
    vectors++;
    if (ifid_valid !== 1'b0 || imem.req !== 1'b1 || imem.addr !== 32'h200) begin
      miscompares++;
      $display("FAIL rgnt_drop: v=%0b req=%0b addr=%h, want 0/1/00000200", ifid_valid, imem.req, imem.addr);
    end
    hold     = 1'b0;
    imem.gnt = 1'b1;
    step();
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b1;
    imem.rdata  = 32'h3C01_1234;
    step();
    imem.rvalid = 1'b0;
    vectors++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 32'h3C01_1234 || ifid_pc4 !== 32'h204) begin
      miscompares++;
      $display("FAIL rgnt_refetch: v=%0b i=%h p=%h, want 1/3c011234/00000204", ifid_valid, ifid_instr, ifid_pc4);
    end
  endtask

  task automatic test_gnt_withheld();
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (imem.req !== 1'b1 || imem.addr !== 32'h204 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
        miscompares++;
        $display("FAIL nognt[%0d]: req=%0b addr=%h v=%0b i=%h, want 1/00000204/0/00000000",
                 i, imem.req, imem.addr, ifid_valid, ifid_instr);
      end
    end
    imem.gnt = 1'b1;
    step();
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b1;
    imem.rdata  = 32'hAC0A_0008;
    step();
    imem.rvalid = 1'b0;
    vectors++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 32'hAC0A_0008 || ifid_pc4 !== 32'h208) begin
      miscompares++;
      $display("FAIL nognt_deliver: v=%0b i=%h p=%h, want 1/ac0a0008/00000208", ifid_valid, ifid_instr, ifid_pc4);
    end
  endtask

  task automatic test_reset_mid();
    imem.gnt = 1'b1;
    step();
    imem.gnt = 1'b0;
    reset    = 1'b0;
    #1;
    vectors++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h0 || ifid_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_async: req=%0b addr=%h v=%0b, want 1/00000000/0", imem.req, imem.addr, ifid_valid);
    end
    step();
    reset       = 1'b1;
    imem.rvalid = 1'b1;
    imem.rdata  = 32'h1111_1111;
    step();
    imem.rvalid = 1'b0;
    vectors++;
    if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || imem.req !== 1'b1 || imem.addr !== 32'h0) begin
      miscompares++;
      $display("FAIL midrst_late_rvalid: v=%0b i=%h req=%0b addr=%h, want 0/00000000/1/00000000",
               ifid_valid, ifid_instr, imem.req, imem.addr);
    end
  endtask

`ifdef IF_STAGE_PERF_EN
  task automatic test_perf();
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imem.gnt = 1'b1;
      step();
      imem.gnt    = 1'b0;
      imem.rvalid = 1'b1;
      imem.rdata  = 32'h0000_1000 + i;
      step();
      imem.rvalid = 1'b0;
    end
    hold = 1'b1;
    step();
    step();
    hold = 1'b0;
    step();
    vectors++;
    if (perf_fetched !== 32'd5 || perf_stall !== 32'd2) begin
      miscompares++;
      $display("FAIL perf_counts: fetched=%0d stall=%0d, want 5/2", perf_fetched, perf_stall);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
      miscompares++;
      $display("FAIL perf_reset: fetched=%0d stall=%0d, want 0/0", perf_fetched, perf_stall);
    end
    step();
    reset = 1'b1;
  endtask
`endif

  initial begin
    reset       = 1'b0;
    hold        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0000_0000;
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata  = 32'h0000_0000;
    test_reset();
    test_basic_fetch();
    test_hold_skid();
    test_redirect_wait();
    test_redirect_gnt();
    test_gnt_withheld();
    test_reset_mid();
`ifdef IF_STAGE_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
